// File: rtl/adsb_report_serializer.sv
// Buffers decoded ADS-B messages as report structs and streams each one out
// as a fixed-length AXI-stream packet: magic, sequence, timestamp, powers, status, message.
module adsb_report_serializer #(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          MSG_WIDTH      = 112,
   parameter int          REPORT_DEPTH   = 4,
   parameter logic [31:0] MAGIC_NUM      = 32'hAD5B0001
) (
   input  logic                            Clk,
   input  logic                            Rst,
   input  logic                            Enable,
   input  logic                            Filter_crc_fail,
   input  logic                            Msg_valid,
   input  logic [MSG_WIDTH-1:0]            Msg_data,
   input  logic                            Msg_is_short,
   input  logic                            Msg_crc_ok,
   input  logic [63:0]                     Msg_timestamp,
   input  logic [31:0]                     Msg_preamble_s,
   input  logic [31:0]                     Msg_preamble_sn,
   input  logic                            M_axis_ready,
   output logic                            M_axis_valid,
   output logic [AXI_DATA_WIDTH-1:0]       M_axis_data,
   output logic                            M_axis_last,
   output logic [31:0]                     Dropped_count,
   output logic [$clog2(REPORT_DEPTH):0]   Reports_pending
);

   localparam int PTR_W   = $clog2(REPORT_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int RPT_W   = 224 + MSG_WIDTH;
   localparam int N_WORDS = (RPT_W + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
   localparam int FLAT_W  = N_WORDS * AXI_DATA_WIDTH;
   localparam int PAD_W   = FLAT_W - RPT_W;
   localparam int IDX_W   = $clog2(N_WORDS);
   localparam int SHORT_W = MSG_WIDTH / 2;
   localparam logic [MSG_WIDTH-1:0] SHORT_MASK =
      ~((MSG_WIDTH'(1) << SHORT_W) - MSG_WIDTH'(1));

   typedef enum logic {S_IDLE, S_SEND} state_t;

   typedef struct packed {
      logic [31:0]          seq;
      logic [63:0]          ts;
      logic [31:0]          ps;
      logic [31:0]          psn;
      logic                 is_short;
      logic                 crc_ok;
      logic [MSG_WIDTH-1:0] msg;
   } report_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_word_idx;
   report_t            r_mem [REPORT_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [31:0]        r_seq;
   logic [31:0]        r_dropped;

   state_t             w_state_nxt;
   logic [IDX_W-1:0]   w_word_idx_nxt;
   logic               w_accept;
   logic               w_full;
   logic               w_push;
   logic               w_drop;
   logic               w_fire;
   logic               w_last_word;
   logic               w_pop;
   report_t            w_new;
   report_t            w_head;
   logic [RPT_W-1:0]   w_rpt_bits;
   logic [FLAT_W-1:0]  w_flat;
   logic [FLAT_W-1:0]  w_flat_shift;

   // Dropped messages still consume a sequence number so the host sees the gap.
   assign w_accept    = Msg_valid && Enable && !(Filter_crc_fail && !Msg_crc_ok);
   assign w_full      = (r_count == CNT_W'(REPORT_DEPTH));
   assign w_push      = w_accept && !w_full;
   assign w_drop      = w_accept && w_full;
   assign w_fire      = (r_state == S_SEND) && M_axis_ready;
   assign w_last_word = (r_word_idx == IDX_W'(N_WORDS - 1));
   assign w_pop       = w_fire && w_last_word;

   always_comb begin
      w_new          = '0;
      w_new.seq      = r_seq;
      w_new.ts       = Msg_timestamp;
      w_new.ps       = Msg_preamble_s;
      w_new.psn      = Msg_preamble_sn;
      w_new.is_short = Msg_is_short;
      w_new.crc_ok   = Msg_crc_ok;
      w_new.msg      = Msg_is_short ? (Msg_data & SHORT_MASK) : Msg_data;
   end

   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_new;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_seq     <= '0;
         r_dropped <= '0;
      end else begin
         if (w_accept) begin
            r_seq <= r_seq + 32'd1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (w_drop && (r_dropped != 32'hFFFF_FFFF)) begin
            r_dropped <= r_dropped + 32'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state    <= S_IDLE;
         r_word_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_word_idx <= w_word_idx_nxt;
      end
   end

   // On the final word the next head (including one written this cycle) follows with no bubble.
   always_comb begin
      w_state_nxt    = r_state;
      w_word_idx_nxt = r_word_idx;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_state_nxt    = S_SEND;
               w_word_idx_nxt = '0;
            end
         end
         S_SEND: begin
            if (w_fire) begin
               if (w_last_word) begin
                  w_word_idx_nxt = '0;
                  if ((r_count == CNT_W'(1)) && !w_push) begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_word_idx_nxt = r_word_idx + IDX_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The head entry and word index only change on a handshake, so valid/data/last
   // stay put while M_axis_ready is low.
   assign w_head     = r_mem[r_rd_ptr];
   assign w_rpt_bits = {MAGIC_NUM, w_head.seq, w_head.ts, w_head.ps, w_head.psn,
                        30'd0, w_head.is_short, w_head.crc_ok, w_head.msg};
   assign w_flat       = FLAT_W'(w_rpt_bits) << PAD_W;
   assign w_flat_shift = w_flat << (int'(r_word_idx) * AXI_DATA_WIDTH);

   assign M_axis_valid    = (r_state == S_SEND);
   assign M_axis_data     = (r_state == S_SEND) ? w_flat_shift[FLAT_W-1 -: AXI_DATA_WIDTH] : '0;
   assign M_axis_last     = (r_state == S_SEND) && w_last_word;
   assign Dropped_count   = r_dropped;
   assign Reports_pending = r_count;

endmodule

// File: tb/tb_adsb_report_serializer.sv
// Directed bench for adsb_report_serializer: a 32-bit and a 64-bit instance share
// the message inputs and are selected by their own Enable.
module tb_adsb_report_serializer;

   localparam logic [31:0] MAGIC = 32'hAD5B0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         en32 = 1'b0, en64 = 1'b0, filt = 1'b0;
   logic         mv = 1'b0, ms = 1'b0, mc = 1'b0;
   logic [111:0] md = '0;
   logic [63:0]  mts = '0;
   logic [31:0]  mps = '0, mpsn = '0;
   logic         rdy32 = 1'b0, rdy64 = 1'b0;

   logic         v32, l32, v64, l64;
   logic [31:0]  d32, drop32, drop64;
   logic [63:0]  d64;
   logic [2:0]   pend32, pend64;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pkts64 = 0;

   logic [31:0] got32_q[$];
   bit          gotl32_q[$];
   logic [63:0] got64_q[$];
   bit          gotl64_q[$];
   int          cyc64_q[$];
   logic [63:0] exp_q[$];
   bit          expl_q[$];

   adsb_report_serializer #(.AXI_DATA_WIDTH(32)) u_dut32 (
      .Clk(clk), .Rst(rst), .Enable(en32), .Filter_crc_fail(filt),
      .Msg_valid(mv), .Msg_data(md), .Msg_is_short(ms), .Msg_crc_ok(mc),
      .Msg_timestamp(mts), .Msg_preamble_s(mps), .Msg_preamble_sn(mpsn),
      .M_axis_ready(rdy32), .M_axis_valid(v32), .M_axis_data(d32), .M_axis_last(l32),
      .Dropped_count(drop32), .Reports_pending(pend32)
   );

   adsb_report_serializer #(.AXI_DATA_WIDTH(64)) u_dut64 (
      .Clk(clk), .Rst(rst), .Enable(en64), .Filter_crc_fail(filt),
      .Msg_valid(mv), .Msg_data(md), .Msg_is_short(ms), .Msg_crc_ok(mc),
      .Msg_timestamp(mts), .Msg_preamble_s(mps), .Msg_preamble_sn(mpsn),
      .M_axis_ready(rdy64), .M_axis_valid(v64), .M_axis_data(d64), .M_axis_last(l64),
      .Dropped_count(drop64), .Reports_pending(pend64)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Collectors: capture handshakes, and hold outputs to the AXI stall rule.
   logic        p_v32 = 1'b0, p_r32 = 1'b0, p_l32 = 1'b0;
   logic [31:0] p_d32 = '0;
   logic        p_v64 = 1'b0, p_r64 = 1'b0, p_l64 = 1'b0;
   logic [63:0] p_d64 = '0;
   logic        p_rst = 1'b1;

   always @(negedge clk) begin
      if (!rst && !p_rst && p_v32 && !p_r32) begin
         chk("stall_v32", v32, 1);
         chk("stall_d32", d32, p_d32);
         chk("stall_l32", l32, p_l32);
      end
      if (!rst && !p_rst && p_v64 && !p_r64) begin
         chk("stall_v64", v64, 1);
         chk("stall_d64", d64, p_d64);
         chk("stall_l64", l64, p_l64);
      end
      if (!rst && v32 && rdy32) begin
         got32_q.push_back(d32);
         gotl32_q.push_back(l32);
      end
      if (!rst && v64 && rdy64) begin
         got64_q.push_back(d64);
         gotl64_q.push_back(l64);
         cyc64_q.push_back(cyc);
         if (l64) pkts64 <= pkts64 + 1;
      end
      p_v32 <= v32; p_r32 <= rdy32; p_l32 <= l32; p_d32 <= d32;
      p_v64 <= v64; p_r64 <= rdy64; p_l64 <= l64; p_d64 <= d64;
      p_rst <= rst;
   end

   function automatic logic [383:0] build_report(input logic [31:0] seq, input logic [63:0] ts,
                                                 input logic [31:0] ps, input logic [31:0] psn,
                                                 input logic crc, input logic short,
                                                 input logic [111:0] msg);
      logic [111:0] m;
      m = short ? {msg[111:56], 56'd0} : msg;
      return {MAGIC, seq, ts, ps, psn, 30'd0, short, crc, m, 48'd0};
   endfunction

   function automatic logic [111:0] f_msg(input int i);
      logic [15:0] h;
      h = 16'(i * 7 + 3);
      return {7{h}};
   endfunction
   function automatic logic        f_short(input int i); return (i % 3) == 0; endfunction
   function automatic logic        f_crc(input int i);   return (i % 2) == 1; endfunction
   function automatic logic [63:0] f_ts(input int i);    return {32'hC0FFEE00, 32'(i)}; endfunction
   function automatic logic [31:0] f_ps(input int i);    return 32'h50000000 + 32'(i); endfunction
   function automatic logic [31:0] f_psn(input int i);   return 32'h60000000 + 32'(i); endfunction

   task automatic push_exp(input logic [383:0] rep, input int w);
      if (w == 32) begin
         for (int i = 0; i < 11; i++) begin
            exp_q.push_back(64'(rep[383 - 32*i -: 32]));
            expl_q.push_back(i == 10);
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            exp_q.push_back(rep[383 - 64*i -: 64]);
            expl_q.push_back(i == 5);
         end
      end
   endtask

   task automatic exp_idx(input int i, input logic [31:0] seq, input int w);
      push_exp(build_report(seq, f_ts(i), f_ps(i), f_psn(i), f_crc(i), f_short(i), f_msg(i)), w);
   endtask

   task automatic cmp32(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (got32_q.size() == 0 || exp_q.size() == 0) break;
         chk({tag, "_d"}, 64'(got32_q.pop_front()), exp_q.pop_front());
         chk({tag, "_l"}, 64'(gotl32_q.pop_front()), 64'(expl_q.pop_front()));
      end
   endtask

   task automatic cmp64(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (got64_q.size() == 0 || exp_q.size() == 0) break;
         chk({tag, "_d"}, got64_q.pop_front(), exp_q.pop_front());
         chk({tag, "_l"}, 64'(gotl64_q.pop_front()), 64'(expl_q.pop_front()));
      end
   endtask

   task automatic clear_q();
      got32_q.delete(); gotl32_q.delete();
      got64_q.delete(); gotl64_q.delete(); cyc64_q.delete();
      exp_q.delete(); expl_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_msg(input logic [111:0] data, input logic short, input logic crc,
                           input logic [63:0] ts, input logic [31:0] ps, input logic [31:0] psn);
      md = data; ms = short; mc = crc; mts = ts; mps = ps; mpsn = psn; mv = 1'b1;
      @(posedge clk);
      #1 mv = 1'b0;
   endtask

   task automatic send_idx(input int i);
      send_msg(f_msg(i), f_short(i), f_crc(i), f_ts(i), f_ps(i), f_psn(i));
   endtask

   task automatic wait_words32(input string tag, input int n, input int budget);
      int k = 0;
      while (got32_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(tag, got32_q.size(), n);
   endtask

   task automatic wait_words64(input string tag, input int n, input int budget);
      int k = 0;
      while (got64_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(tag, got64_q.size(), n);
   endtask

   logic [31:0] t1_exp [11] = '{32'hAD5B0001, 32'h00000000, 32'h00000000, 32'h00001234,
                                32'h11112222, 32'h33334444, 32'h00000001, 32'h8D4840D6,
                                32'h202CC371, 32'hC32CE057, 32'h60980000};
   logic [31:0] t2_exp [11] = '{32'hAD5B0001, 32'h00000001, 32'hFEDCBA98, 32'h76543210,
                                32'h0000000A, 32'h0000000B, 32'h00000003, 32'h5D4840D6,
                                32'hABCDEF00, 32'h00000000, 32'h00000000};

   logic        rdy_done;
   logic [31:0] drop_before;
   logic [63:0] w0;
   int          prev_seq;

   initial begin
      do_reset();
      chk("rst_valid", v32, 0);
      chk("rst_last", l32, 0);
      chk("rst_data", d32, 0);
      chk("rst_drop", drop32, 0);
      chk("rst_pend", pend32, 0);
      chk("rst_valid64", v64, 0);

      // Long message, latency and hand-computed words.
      en32 = 1'b1; rdy32 = 1'b1;
      send_msg(112'h8D4840D6202CC371C32CE0576098, 1'b0, 1'b1, 64'h1234, 32'h11112222, 32'h33334444);
      @(negedge clk);
      chk("lat_n1_valid", v32, 0);
      @(negedge clk);
      chk("lat_n2_valid", v32, 1);
      chk("lat_n2_data", d32, MAGIC);
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back(64'(t1_exp[i]));
         expl_q.push_back(i == 10);
      end
      wait_words32("t1_rx", 11, 60);
      cmp32("t1", 11);

      // Short message: low half forced to zero, sequence 1.
      send_msg({56'h5D4840D6ABCDEF, 56'h123456789ABCDE}, 1'b1, 1'b1,
               64'hFEDCBA9876543210, 32'h0000000A, 32'h0000000B);
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back(64'(t2_exp[i]));
         expl_q.push_back(i == 10);
      end
      wait_words32("t2_rx", 11, 60);
      cmp32("t2", 11);

      // CRC filtering, Enable low mid-packet, then filter off.
      do_reset();
      clear_q();
      filt = 1'b1;
      send_idx(20);
      send_idx(21);
      send_idx(22);
      en32 = 1'b0;
      send_idx(23);
      exp_idx(21, 32'd0, 32);
      wait_words32("t3_rx", 11, 60);
      cmp32("t3", 11);
      en32 = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("t3_extra", got32_q.size(), 0);
      chk("t3_drop", drop32, 0);
      chk("t3_pend", pend32, 0);
      filt = 1'b0;
      send_idx(24);
      exp_idx(24, 32'd1, 32);
      wait_words32("t3b_rx", 11, 60);
      cmp32("t3b", 11);

      // Overflow with ready held low.
      do_reset();
      clear_q();
      rdy32 = 1'b0;
      for (int i = 0; i < 6; i++) send_idx(i);
      chk("t4_pend", pend32, 4);
      chk("t4_drop", drop32, 2);
      repeat (5) @(posedge clk);
      #1;
      chk("t4_stalled_rx", got32_q.size(), 0);
      rdy32 = 1'b1;
      for (int i = 0; i < 4; i++) exp_idx(i, 32'(i), 32);
      wait_words32("t4_rx", 44, 120);
      cmp32("t4", 44);
      send_idx(6);
      exp_idx(6, 32'd6, 32);
      wait_words32("t4b_rx", 11, 60);
      cmp32("t4b", 11);
      chk("t4_pend_end", pend32, 0);
      chk("t4_drop_end", drop32, 2);

      // 64-bit width, random ready, back-to-back messages.
      do_reset();
      clear_q();
      en32 = 1'b0; en64 = 1'b1; rdy64 = 1'b0;
      pkts64 = 0;
      rdy_done = 1'b0;
      fork
         begin
            int k = 0;
            for (int i = 0; i < 50; i++) send_idx(i);
            while ((pkts64 + int'(drop64)) < 50 && k < 3000) begin
               @(posedge clk);
               k++;
            end
            #1 rdy_done = 1'b1;
         end
         begin
            while (!rdy_done) begin
               rdy64 = ($urandom_range(0, 99) < 80);
               @(posedge clk);
               #1;
            end
         end
      join
      rdy64 = 1'b1;
      chk("t5_total", pkts64 + int'(drop64), 50);
      chk("t5_words", got64_q.size(), pkts64 * 6);
      prev_seq = -1;
      while (got64_q.size() >= 6) begin
         w0 = got64_q[0];
         chk("t5_order", int'(w0[31:0]) > prev_seq, 1);
         chk("t5_range", w0[31:0] < 32'd50, 1);
         exp_idx(int'(w0[31:0]), w0[31:0], 64);
         cmp64("t5", 6);
         prev_seq = int'(w0[31:0]);
      end
      exp_q.delete(); expl_q.delete();

      clear_q();
      drop_before = drop64;
      for (int i = 50; i < 54; i++) send_idx(i);
      for (int i = 50; i < 54; i++) exp_idx(i, 32'(i), 64);
      wait_words64("t5b_rx", 24, 80);
      if (cyc64_q.size() >= 24) chk("t5_nobubble", cyc64_q[23] - cyc64_q[0], 23);
      chk("t5b_drop", drop64, drop_before);
      cmp64("t5b", 24);
      chk("t5_pend_end", pend64, 0);

      // Reset while word 5 of a packet is on the bus.
      en64 = 1'b0; en32 = 1'b1; rdy32 = 1'b1;
      do_reset();
      clear_q();
      send_idx(30);
      begin
         int k = 0;
         while (got32_q.size() < 5 && k < 40) begin
            @(posedge clk);
            k++;
         end
      end
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_valid", v32, 0);
      chk("t6_pend", pend32, 0);
      chk("t6_drop", drop32, 0);
      chk("t6_partial", got32_q.size(), 5);
      @(posedge clk);
      #1;
      repeat (15) @(posedge clk);
      #1;
      chk("t6_no_resume", got32_q.size(), 5);
      clear_q();
      send_idx(31);
      exp_idx(31, 32'd0, 32);
      wait_words32("t6_rx", 11, 60);
      cmp32("t6", 11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
